// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and the feeder state encoding
package conv_pkg;
    localparam int CONV_BIT_LEN = 8;
    localparam int CONV_M_LEN   = 3;
    typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_I, PUSH_K, STRIP, DRAIN} state_t;
endpackage

// File: rtl/frame_buf.sv
// frame_buf: IMG_W*IMG_H pixel store, one write port, three combinational reads (row, col..col+2)
module frame_buf
    import conv_pkg::*;
#(
    parameter int BIT_LEN = CONV_BIT_LEN,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    localparam int AW     = $clog2(IMG_W * IMG_H),
    localparam int RW     = $clog2(IMG_H),
    localparam int CW     = $clog2(IMG_W)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [BIT_LEN-1:0] i_wdata,
    input  logic [RW-1:0]      i_row,
    input  logic [CW-1:0]      i_col,
    output logic [BIT_LEN-1:0] o_rd0,
    output logic [BIT_LEN-1:0] o_rd1,
    output logic [BIT_LEN-1:0] o_rd2
);
    logic [BIT_LEN-1:0] mem [IMG_W*IMG_H];
    logic [AW-1:0] base;
    assign base  = AW'(i_row) * AW'(IMG_W) + AW'(i_col);
    assign o_rd0 = mem[base];
    assign o_rd1 = mem[base + AW'(1)];
    assign o_rd2 = mem[base + AW'(2)];
    always_ff @(posedge i_clk)
        if (i_we) mem[i_waddr] <= i_wdata;
endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: loads a 3x3 kernel and an image, then streams kernel rows and image column strips into a convolution stage
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int BIT_LEN = CONV_BIT_LEN,
    parameter int M_LEN   = CONV_M_LEN,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic                       i_pix_valid,
    input  logic [BIT_LEN-1:0]         i_pix_data,
    output logic                       o_pix_ready,
    output logic                       o_valid,
    output logic                       o_selecK_I,
    output logic [BIT_LEN-1:0]         o_data0,
    output logic [BIT_LEN-1:0]         o_data1,
    output logic [BIT_LEN-1:0]         o_data2,
    output logic                       o_win_valid,
    output logic [$clog2(IMG_H)-1:0]   o_win_row,
    output logic [$clog2(IMG_W)-1:0]   o_win_col,
    output logic                       o_busy,
    output logic                       o_done
);
    localparam int N  = IMG_W * IMG_H;
    localparam int AW = $clog2(N);
    localparam int KN = M_LEN * M_LEN;
    localparam int KW = $clog2(KN);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    state_t state;
    logic [AW-1:0] cnt;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [KW-1:0] kr;
    logic drn;
    logic [BIT_LEN-1:0] kreg [KN];
    logic [BIT_LEN-1:0] rd0, rd1, rd2;
    // window tag pipeline: a push is registered with w0, o_win_valid follows two edges later
    logic w0, w1, l0, l1;
    logic [RW-1:0] w0_row, w1_row;
    logic [CW-1:0] w0_col, w1_col;
    logic xfer;
    logic [KW-1:0] ki;
    assign xfer = i_pix_valid & o_pix_ready;
    assign ki   = kr * KW'(M_LEN);
    frame_buf #(.BIT_LEN(BIT_LEN), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_fb (
        .i_clk  (i_clk),
        .i_we   (xfer && state == LOAD_I),
        .i_waddr(cnt),
        .i_wdata(i_pix_data),
        .i_row  (row),
        .i_col  (col),
        .o_rd0  (rd0),
        .o_rd1  (rd1),
        .o_rd2  (rd2)
    );
    always_ff @(posedge i_clk)
        if (xfer && state == LOAD_K) kreg[cnt[KW-1:0]] <= i_pix_data;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            row         <= '0;
            col         <= '0;
            kr          <= '0;
            drn         <= 1'b0;
            w0          <= 1'b0;
            w1          <= 1'b0;
            l0          <= 1'b0;
            l1          <= 1'b0;
            w0_row      <= '0;
            w1_row      <= '0;
            w0_col      <= '0;
            w1_col      <= '0;
            o_pix_ready <= 1'b0;
            o_valid     <= 1'b0;
            o_selecK_I  <= 1'b0;
            o_data0     <= '0;
            o_data1     <= '0;
            o_data2     <= '0;
            o_win_valid <= 1'b0;
            o_win_row   <= '0;
            o_win_col   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            w0          <= 1'b0;
            l0          <= 1'b0;
            w1          <= w0;
            l1          <= l0;
            w1_row      <= w0_row;
            w1_col      <= w0_col;
            o_win_valid <= w1;
            o_done      <= l1;
            o_win_row   <= w1_row;
            o_win_col   <= w1_col;
            case (state)
                IDLE: if (i_start) begin
                    state       <= LOAD_K;
                    cnt         <= '0;
                    o_busy      <= 1'b1;
                    o_pix_ready <= 1'b1;
                end
                LOAD_K: if (xfer) begin
                    cnt   <= (cnt == AW'(KN - 1)) ? '0 : cnt + AW'(1);
                    state <= (cnt == AW'(KN - 1)) ? LOAD_I : LOAD_K;
                end
                LOAD_I: if (xfer) begin
                    if (cnt == AW'(N - 1)) begin
                        cnt         <= '0;
                        kr          <= '0;
                        state       <= PUSH_K;
                        o_pix_ready <= 1'b0;
                    end else cnt <= cnt + AW'(1);
                end
                PUSH_K: begin
                    o_valid    <= 1'b1;
                    o_selecK_I <= 1'b0;
                    o_data0    <= kreg[ki];
                    o_data1    <= kreg[ki + KW'(1)];
                    o_data2    <= kreg[ki + KW'(2)];
                    kr         <= kr + KW'(1);
                    if (kr == KW'(M_LEN - 1)) begin
                        state <= STRIP;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                STRIP: begin
                    o_valid    <= 1'b1;
                    o_selecK_I <= 1'b1;
                    o_data0    <= rd0;
                    o_data1    <= rd1;
                    o_data2    <= rd2;
                    // rows 0 and 1 of a strip only refill the stage's row history
                    w0         <= row >= RW'(M_LEN - 1);
                    w0_row     <= row - RW'(M_LEN - 1);
                    w0_col     <= col;
                    l0         <= row == RW'(IMG_H - 1) && col == CW'(IMG_W - M_LEN);
                    row        <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
                    if (row == RW'(IMG_H - 1)) begin
                        if (col == CW'(IMG_W - M_LEN)) begin
                            state <= DRAIN;
                            drn   <= 1'b0;
                        end else col <= col + CW'(1);
                    end
                end
                DRAIN: begin
                    drn <= 1'b1;
                    if (drn) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: table-driven frame tests with a behavioural convolution stage model
module tb_conv_window_feeder;
    logic       i_clk = 1'b0;
    logic       i_reset, i_start, i_pix_valid;
    logic [7:0] i_pix_data;
    logic       o_pix_ready, o_valid, o_selecK_I, o_win_valid, o_busy, o_done;
    logic [7:0] o_data0, o_data1, o_data2;
    logic [2:0] o_win_row, o_win_col;
    int checks = 0, errors = 0;
    typedef struct {
        int km; int gap; int strt; int w00; int w55; int nwin; int npush; int nxfer;
    } vec_t;
    vec_t tbl[4];
    always #5 i_clk = ~i_clk;
    conv_window_feeder dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_pix_valid(i_pix_valid),
        .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready), .o_valid(o_valid),
        .o_selecK_I(o_selecK_I), .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2),
        .o_win_valid(o_win_valid), .o_win_row(o_win_row), .o_win_col(o_win_col),
        .o_busy(o_busy), .o_done(o_done)
    );
    // convolution stage model: rows shift in on each push, the window sum appears two cycles later
    logic [23:0] km0, km1, km2, im1, im2;
    logic [23:0] row_now;
    int sd1, sd2;
    assign row_now = {o_data0, o_data1, o_data2};
    function automatic int dot3(input logic [23:0] k, input logic [23:0] x);
        return int'(k[23:16]) * int'(x[23:16]) + int'(k[15:8]) * int'(x[15:8]) + int'(k[7:0]) * int'(x[7:0]);
    endfunction
    always @(posedge i_clk) begin
        sd2 <= sd1;
        if (o_valid && !o_selecK_I) begin
            km0 <= km1; km1 <= km2; km2 <= row_now;
        end
        if (o_valid && o_selecK_I) begin
            im1 <= im2; im2 <= row_now;
            sd1 <= dot3(km0, im1) + dot3(km1, im2) + dot3(km2, row_now);
        end
    end
    function automatic int exp_sum(input int km, input int r, input int c);
        return km == 0 ? 9 * (8 * r + c) + 81 : 8 * (r + 1) + (c + 1);
    endfunction
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, {o_data0, o_data1, o_data2}, 0);
        chk({tag, "_flags"}, {o_valid, o_selecK_I, o_win_valid, o_win_row, o_win_col, o_busy, o_done, o_pix_ready}, 0);
    endtask
    task automatic run_frame(input vec_t v, input int abort);
        logic [7:0] seq[73];
        int idx, extra, ip, kp, nwin, ndone, post, w00, w55, cyc, er, ec;
        logic vv;
        for (int i = 0; i < 9; i++) seq[i] = (v.km == 0 || i == 4) ? 8'd1 : 8'd0;
        for (int i = 0; i < 64; i++) seq[9 + i] = 8'(i);
        idx = 0; extra = 0; ip = 0; kp = 0; nwin = 0; ndone = 0; post = 0; w00 = -1; w55 = -1; cyc = 0;
        @(negedge i_clk) i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
        while (idx < 73 && cyc < 2000) begin
            @(negedge i_clk);
            cyc++;
            vv = v.gap != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            i_pix_valid = vv;
            i_pix_data  = seq[idx];
            if (vv && o_pix_ready) idx++;
        end
        chk("load_budget", idx, 73);
        for (int c = 0; c < 600 && post < 6; c++) begin
            @(negedge i_clk);
            i_pix_valid = 1'b1;
            i_pix_data  = 8'hFF;
            if (o_pix_ready) extra++;
            if (v.strt != 0) i_start = (ip == 20);
            if (o_valid && !o_selecK_I) begin
                if (kp < 3) chk("kern_row", row_now, {seq[3 * kp], seq[3 * kp + 1], seq[3 * kp + 2]});
                kp++;
            end
            if (o_valid && o_selecK_I) begin
                er = ip % 8; ec = ip / 8;
                if (ip < 48) chk("img_row", row_now, {8'(8 * er + ec), 8'(8 * er + ec + 1), 8'(8 * er + ec + 2)});
                ip++;
                if (abort > 0 && ip == abort) begin
                    #1 i_reset = 1'b1;
                    #1 chk_zero("rst_mid");
                    #1 i_reset = 1'b0;
                    i_pix_valid = 1'b0;
                    i_start = 1'b0;
                    return;
                end
            end
            if (o_win_valid) begin
                er = nwin % 6; ec = nwin / 6;
                chk("win_row", o_win_row, er);
                chk("win_col", o_win_col, ec);
                chk("win_sum", sd2, exp_sum(v.km, er, ec));
                if (nwin == 0) w00 = sd2;
                if (nwin == 35) w55 = sd2;
                nwin++;
                if (o_done) chk("done_at_last", nwin, v.nwin);
            end
            if (o_done) ndone++;
            if (ndone > 0) post++;
        end
        i_pix_valid = 1'b0;
        i_start = 1'b0;
        chk("windows", nwin, v.nwin);
        chk("img_pushes", ip, v.npush);
        chk("kern_pushes", kp, 3);
        chk("xfers", idx + extra, v.nxfer);
        chk("done_pulses", ndone, 1);
        chk("win_0_0", w00, v.w00);
        chk("win_5_5", w55, v.w55);
        chk("idle_after", o_busy, 0);
    endtask
    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_pix_valid = 1'b0; i_pix_data = '0;
        tbl[0] = '{km: 0, gap: 0, strt: 0, w00: 81, w55: 486, nwin: 36, npush: 48, nxfer: 73};
        tbl[1] = '{km: 1, gap: 0, strt: 0, w00: 9,  w55: 54,  nwin: 36, npush: 48, nxfer: 73};
        tbl[2] = '{km: 0, gap: 1, strt: 0, w00: 81, w55: 486, nwin: 36, npush: 48, nxfer: 73};
        tbl[3] = '{km: 0, gap: 0, strt: 1, w00: 81, w55: 486, nwin: 36, npush: 48, nxfer: 73};
        repeat (3) @(posedge i_clk);
        #1 chk_zero("rst_init");
        @(negedge i_clk) i_reset = 1'b0;
        for (int i = 0; i < 4; i++) run_frame(tbl[i], 0);
        run_frame(tbl[0], 10);
        run_frame(tbl[0], 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
